// File: rtl/bit_serializer_if.sv
// Word-in / bit-out handshake bundle for bit_serializer.
// master = upstream word source + serial sink, slave = serializer.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             last;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  out,
    input  out_valid,
    input  busy,
    input  last
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output out,
    output out_valid,
    output busy,
    output last
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one WIDTH-bit word per handshake, one bit per clock.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input logic          clock,
  input logic          reset,
  bit_serializer_if.slave bus
);
  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_e;
  logic par_q, par_d;
`else
  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

  assign accept = bus.din_valid && bus.din_ready;

  // Zero-fill from the far end so the next bit lands on the output tap.
  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
`ifdef SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    // Accept only happens on a ready cycle; it always (re)starts a word.
    if (accept) begin
      state_d = SHIFT;
      shreg_d = bus.din;
      cnt_d   = CNT_LAST;
`ifdef SERIALIZER_PARITY_EN
      par_d   = ^bus.din;
`endif
    end
  end

  always_comb begin
    bus.din_ready = 1'b0;
    bus.out       = IDLE_LEVEL;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.last      = 1'b0;
    unique case (state_q)
      IDLE: bus.din_ready = 1'b1;
      SHIFT: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.out       = MSB_FIRST ? shreg_q[WIDTH-1]
                                  : shreg_q[0];
`ifndef SERIALIZER_PARITY_EN
        if (cnt_q == '0) begin
          bus.last      = 1'b1;
          bus.din_ready = 1'b1;
        end
`endif
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.out       = par_q;
        bus.last      = 1'b1;
        bus.din_ready = 1'b1;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_bit_serializer.sv
// Randomized bench for bit_serializer against a bit-queue model.
// Two instances share stimulus: MSB-first/idle 0 and LSB-first/idle 1.
module tb_bit_serializer;
  localparam int unsigned W = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  bit_serializer_if #(.WIDTH(W)) bm ();
  bit_serializer_if #(.WIDTH(W)) bl ();

  bit_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
  ) u_msb (
    .clock(clock), .reset(reset), .bus(bm)
  );

  bit_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)
  ) u_lsb (
    .clock(clock), .reset(reset), .bus(bl)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Pending serial bits per instance; head is the bit on the line now.
  bit qm[$];
  bit ql[$];
  bit qlast[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_outs();
    logic vld;
    logic rdy;
    vld = (qm.size() != 0);
    rdy = (qm.size() <= 1);
    chk("m_valid", bm.out_valid, vld);
    chk("m_busy",  bm.busy,      vld);
    chk("m_ready", bm.din_ready, rdy);
    chk("m_last",  bm.last,  vld ? qlast[0] : 1'b0);
    chk("m_out",   bm.out,   vld ? qm[0]    : 1'b0);
    chk("l_valid", bl.out_valid, vld);
    chk("l_busy",  bl.busy,      vld);
    chk("l_ready", bl.din_ready, rdy);
    chk("l_last",  bl.last,  vld ? qlast[0] : 1'b0);
    chk("l_out",   bl.out,   vld ? ql[0]    : 1'b1);
  endtask

  function automatic void push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      qm.push_back(d[W-1-i]);
      ql.push_back(d[i]);
      qlast.push_back(1'b0);
    end
`ifdef SERIALIZER_PARITY_EN
    qm.push_back(^d);
    ql.push_back(^d);
    qlast.push_back(1'b1);
`else
    qlast[qlast.size()-1] = 1'b1;
`endif
  endfunction

  function automatic void clear_model();
    qm.delete();
    ql.delete();
    qlast.delete();
  endfunction

  // One clock: present inputs, advance model at the edge, check mid-cycle.
  task automatic drive(input logic v, input logic [W-1:0] d);
    logic acc;
    bm.din_valid = v;
    bl.din_valid = v;
    bm.din       = d;
    bl.din       = d;
    acc = v && (qm.size() <= 1);
    @(posedge clock);
    if (qm.size() != 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
      void'(qlast.pop_front());
    end
    if (acc) push_word(d);
    @(negedge clock);
    check_outs();
  endtask

  task automatic send(input logic [W-1:0] d);
    logic acc;
    for (int k = 0; k < 2 * W + 4; k++) begin
      acc = (qm.size() <= 1);
      drive(1'b1, d);
      if (acc) return;
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, W'($urandom));
  endtask

  initial begin
    bm.din_valid = 1'b1;
    bl.din_valid = 1'b1;
    bm.din       = 8'h5A;
    bl.din       = 8'h5A;
    reset        = 1'b0;
    clear_model();
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check_outs();
    end
    bm.din_valid = 1'b0;
    bl.din_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_outs();

    send(8'h60);
    idle(W + 3);

    send(8'hA5);
    send(8'h3C);
    idle(W + 3);

    send(8'h96);
    idle(2);
    drive(1'b1, 8'h0F);
    idle(W + 2);
    send(8'h11);
    send(8'hE7);
    idle(W + 3);

    send(8'h01);
    idle(W + 2);
    send(8'h07);
    idle(W + 2);
    send(8'h03);
    idle(W + 2);

    send(8'hFF);
    idle(3);
    reset = 1'b0;
    bm.din_valid = 1'b0;
    bl.din_valid = 1'b0;
    #1;
    clear_model();
    check_outs();
    @(posedge clock);
    @(negedge clock);
    check_outs();
    reset = 1'b1;
    #1;
    check_outs();
    idle(2);

    for (int k = 0; k < 600; k++)
      drive($urandom_range(0, 99) < 65, W'($urandom));
    idle(W + 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
